// File: rtl/selector_pkg.sv
// rtl/selector_pkg.sv - shared state encoding and width helpers for the selector lookup slice
// Optional feature macro used by this slice: SELECTOR_MULTI_HIT_EN
package selector_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Address width for a value range of 'size'; never narrower than one bit.
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Data width for a table of 'depth' entries; never narrower than one bit.
    function automatic int data_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/Selector.sv
// rtl/Selector.sv - combinational associative lookup: OR of data fields whose address equals n
module Selector
    import selector_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int K    = 8,
    localparam int AW  = addr_width(SIZE),
    localparam int DW  = data_width(K),
    localparam int EW  = AW + DW
) (
    input  logic [K*EW-1:0] inputs,
    input  logic [AW-1:0]   n,
    output logic [DW-1:0]   data
);

    // Every entry whose address field equals n contributes its data field.
    always_comb begin
        data = '0;
        for (int i = 0; i < K; i++) begin
            if (inputs[i*EW+DW +: AW] == n) begin
                data = data | inputs[i*EW +: DW];
            end
        end
    end

endmodule

// File: rtl/selector_lookup_ctrl.sv
// rtl/selector_lookup_ctrl.sv - table load / query / response sequencer around Selector (option: SELECTOR_MULTI_HIT_EN)
module selector_lookup_ctrl
    import selector_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int K    = 8,
    localparam int AW  = addr_width(SIZE),
    localparam int DW  = data_width(K),
    localparam int EW  = AW + DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          query_valid,
    output logic          query_ready,
    input  logic [AW-1:0] query_n,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
`ifdef SELECTOR_MULTI_HIT_EN
    output logic          resp_multi,
`endif
    output logic          resp_hit
);

    localparam int CW = count_width(K);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     count;
    logic [K*EW-1:0]   tbl;
    logic [K-1:0]      valid;
    logic [K*EW-1:0]   sel_bus;
    logic [DW-1:0]     sel_data;
    logic [K-1:0]      match;
    logic              load_acc;
    logic              query_acc;

    // clear wins over every same-cycle handshake.
    assign load_acc  = load_valid  && (state == LOAD)  && !clear;
    assign query_acc = query_valid && (state == SERVE) && !clear;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        load_ready  = 1'b0;
        query_ready = 1'b0;
        resp_valid  = 1'b0;
        case (state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_acc && (load_last || (count == CW'(K - 1)))) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                query_ready = 1'b1;
                if (query_acc) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready && !clear) begin
                    state_nxt = SERVE;
                end
            end
            default: state_nxt = LOAD;
        endcase
        if (clear) begin
            state_nxt = LOAD;
        end
    end

    // Table storage, valid bits and fill count; entries fill slots in order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl   <= '0;
            valid <= '0;
            count <= '0;
        end else if (clear) begin
            valid <= '0;
            count <= '0;
        end else if (load_acc) begin
            for (int i = 0; i < K; i++) begin
                if (count == CW'(i)) begin
                    tbl[i*EW +: EW] <= {load_addr, load_data};
                    valid[i]        <= 1'b1;
                end
            end
            count <= count + CW'(1);
        end
    end

    // Invalid slots are presented to Selector as zero so stale contents left
    // after a clear can never leak into resp_data.
    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < K; i++) begin
            if (valid[i]) begin
                sel_bus[i*EW +: EW] = tbl[i*EW +: EW];
            end
        end
    end

    // Per-slot hit vector: only valid entries can report a match.
    always_comb begin
        match = '0;
        for (int i = 0; i < K; i++) begin
            match[i] = valid[i] && (tbl[i*EW+DW +: AW] == query_n);
        end
    end

    Selector #(
        .SIZE (SIZE),
        .K    (K)
    ) u_selector (
        .inputs (sel_bus),
        .n      (query_n),
        .data   (sel_data)
    );

`ifdef SELECTOR_MULTI_HIT_EN
    logic [CW-1:0] hit_count;

    // Number of valid entries matching the query.
    always_comb begin
        hit_count = '0;
        for (int i = 0; i < K; i++) begin
            hit_count = hit_count + CW'(match[i]);
        end
    end

    // Response registers, captured on query acceptance and held until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_data  <= '0;
            resp_hit   <= 1'b0;
            resp_multi <= 1'b0;
        end else if (query_acc) begin
            resp_data  <= sel_data;
            resp_hit   <= |match;
            resp_multi <= (hit_count >= CW'(2));
        end
    end
`else
    // Response registers, captured on query acceptance and held until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_hit  <= 1'b0;
        end else if (query_acc) begin
            resp_data <= sel_data;
            resp_hit  <= |match;
        end
    end
`endif

endmodule
